// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: PC, IF/ID register, jump pre-decode, stats counters
module instruction_fetch_unit #(
    parameter int unsigned     ADDR_W         = 8,
    parameter int unsigned     INSTR_W        = 16,
    parameter logic [4:0]      JUMP_OPCODE    = 5'b10101,
    parameter bit              PREDECODE_JUMP = 1'b1,
    parameter logic [INSTR_W-1:0] NOP         = '0,
    parameter int unsigned     CNT_W          = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  mem_address,
    input  logic [INSTR_W-1:0] mem_instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               is_jump;

    assign is_jump = PREDECODE_JUMP && (mem_instruction[INSTR_W-1:INSTR_W-5] == JUMP_OPCODE);

    // Priority: redirect overrides stall; stall freezes everything including counters.
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        id_pc_d     = id_pc_q;
        valid_d     = valid_q;
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            pc_d        = redirect_target;
            instr_d     = NOP;
            id_pc_d     = '0;
            valid_d     = 1'b0;
            flush_cnt_d = (flush_cnt_q == '1) ? flush_cnt_q : flush_cnt_q + CNT_W'(1);
        end else if (!stall) begin
            instr_d     = mem_instruction;
            id_pc_d     = pc_q;
            valid_d     = 1'b1;
            fetch_cnt_d = (fetch_cnt_q == '1) ? fetch_cnt_q : fetch_cnt_q + CNT_W'(1);
            pc_d        = is_jump ? mem_instruction[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= '0;
            instr_q     <= NOP;
            id_pc_q     <= '0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            id_pc_q     <= id_pc_d;
            valid_q     <= valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_address       = pc_q;
    assign pc                = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc          = id_pc_q;
    assign if_id_valid       = valid_q;
    assign fetch_count       = fetch_cnt_q;
    assign flush_count       = flush_cnt_q;

endmodule
